// File: rtl/seq_stim_gen_if.sv
// Request/serial-output bundle for seq_stim_gen. master = stimulus source, slave = generator.
// start is a level request; the generator samples it only while idle (no ready, busy=1 means ignored).
interface seq_stim_gen_if #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4
);
  logic               start;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   length;
  logic               busy;
  logic               done;
  logic               ser_in;
  logic               ser_next;
  logic [LEN_W-1:0]   bit_idx;
  logic               det_reset;
  logic [2:0]         state_dbg;

  modport master (
    output start, pattern, length,
    input  busy, done, ser_in, ser_next, bit_idx, det_reset, state_dbg
  );

  modport slave (
    input  start, pattern, length,
    output busy, done, ser_in, ser_next, bit_idx, det_reset, state_dbg
  );
endinterface

// File: rtl/seq_stim_gen.sv
// Serialises a captured pattern MSB-first as ser_in/ser_next strobes for the sequence detector.
// Optional SEQ_STIM_GEN_DET_RESET_EN inserts a 2-cycle detector reset pulse before the first strobe.
module seq_stim_gen #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int GAP     = 1
) (
  input logic          clk,
  input logic          reset,
  seq_stim_gen_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
`ifdef SEQ_STIM_GEN_DET_RESET_EN
  localparam logic [2:0] S_RSTP  = 3'd1;
`endif
  localparam logic [2:0] S_DRIVE = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] ONE_L     = LEN_W'(1);
  localparam logic [3:0]       GAP_L     = 4'(GAP);

  logic [2:0]         state_q;
  logic [MAX_LEN-1:0] sh_q;
  logic [LEN_W-1:0]   idx_q;
  logic [3:0]         gap_q;
  logic [LEN_W-1:0]   len_cl;

  logic               busy_q;
  logic               done_q;
  logic               ser_in_q;
  logic               ser_next_q;
  logic [LEN_W-1:0]   bit_idx_q;

  assign len_cl = (bus.length > MAX_LEN_L) ? MAX_LEN_L : bus.length;

`ifdef SEQ_STIM_GEN_DET_RESET_EN
  logic rst_q;
  logic det_q;
`endif

  // Control path. The pattern is left-aligned on capture so the next bit is always sh_q MSB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
`ifdef SEQ_STIM_GEN_DET_RESET_EN
      rst_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            sh_q  <= bus.pattern << (MAX_LEN - int'(len_cl));
            idx_q <= len_cl;
`ifdef SEQ_STIM_GEN_DET_RESET_EN
            rst_q   <= 1'b0;
            state_q <= S_RSTP;
`else
            state_q <= (len_cl != '0) ? S_DRIVE : S_FIN;
`endif
          end
        end
`ifdef SEQ_STIM_GEN_DET_RESET_EN
        S_RSTP: begin
          if (rst_q) state_q <= (idx_q != '0) ? S_DRIVE : S_FIN;
          rst_q <= 1'b1;
        end
`endif
        S_DRIVE: begin
          gap_q   <= GAP_L;
          state_q <= S_GAP;
        end
        S_GAP: begin
          if (gap_q == 4'd1) begin
            idx_q   <= idx_q - ONE_L;
            sh_q    <= sh_q << 1;
            state_q <= (idx_q > ONE_L) ? S_DRIVE : S_FIN;
          end else begin
            gap_q <= gap_q - 4'd1;
          end
        end
        S_FIN:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Outputs are registered from the current state, so they trail the state by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ser_in_q   <= 1'b0;
      ser_next_q <= 1'b0;
      bit_idx_q  <= '0;
    end else begin
      busy_q     <= (state_q != S_IDLE);
      done_q     <= (state_q == S_FIN);
      ser_next_q <= (state_q == S_DRIVE);
      bit_idx_q  <= idx_q;
      if (state_q == S_DRIVE) ser_in_q <= sh_q[MAX_LEN-1];
`ifdef SEQ_STIM_GEN_DET_RESET_EN
      else if (state_q == S_RSTP) ser_in_q <= 1'b0;
`endif
    end
  end

`ifdef SEQ_STIM_GEN_DET_RESET_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) det_q <= 1'b0;
    else       det_q <= (state_q == S_RSTP);
  end
  assign bus.det_reset = det_q;
`else
  assign bus.det_reset = 1'b0;
`endif

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.ser_in    = ser_in_q;
  assign bus.ser_next  = ser_next_q;
  assign bus.bit_idx   = bit_idx_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_seq_stim_gen.sv
// Bench for seq_stim_gen: per-cycle output traces compared against a timing model of the serialiser.
module tb_seq_stim_gen;
  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int GAP     = 1;
`ifdef SEQ_STIM_GEN_DET_RESET_EN
  localparam int OFF = 2;
`else
  localparam int OFF = 0;
`endif
  localparam int W = 9;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];

  seq_stim_gen_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) bus ();

  seq_stim_gen #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .GAP(GAP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // {det_reset, busy, done, ser_next, ser_in at strobe, bit_idx at strobe}
  function automatic logic [W-1:0] sample();
    return {bus.det_reset, bus.busy, bus.done, bus.ser_next,
            bus.ser_next & bus.ser_in, bus.ser_next ? bus.bit_idx : 4'd0};
  endfunction

  function automatic logic [9:0] all_outputs();
    return {bus.busy, bus.done, bus.ser_in, bus.ser_next, bus.bit_idx, bus.det_reset, 1'b0};
  endfunction

  function automatic int done_cycle(input int len_req);
    int l;
    l = (len_req > MAX_LEN) ? MAX_LEN : len_req;
    return 1 + OFF + l * (1 + GAP);
  endfunction

  // Reference model: cycle c counted from the accepting edge (cycle 0).
  task automatic build_exp(input logic [7:0] pat, input int len_req, input int ncyc);
    int l, dc, k, s;
    bit strobe, b, dr;
    int idx;
    exp_q.delete();
    l  = (len_req > MAX_LEN) ? MAX_LEN : len_req;
    dc = done_cycle(len_req);
    for (int c = 1; c <= ncyc; c++) begin
      k      = c - 1 - OFF;
      s      = (k >= 0) ? k / (1 + GAP) : 0;
      strobe = (k >= 0) && (k % (1 + GAP) == 0) && (s < l);
      b      = strobe ? pat[l - 1 - s] : 1'b0;
      idx    = strobe ? (l - s) : 0;
      dr     = (c <= OFF);
      exp_q.push_back({dr, (c <= dc), (c == dc), strobe, b, 4'(idx)});
    end
  endtask

  // Driver + monitor: start pulse, then record ncyc cycles sampled 1 time unit after each edge.
  task automatic run(input logic [7:0] pat, input logic [3:0] len, input int ncyc,
                     input int restart_at, input bit chain);
    obs_q.delete();
    @(negedge clk);
    bus.start   = 1'b1;
    bus.pattern = pat;
    bus.length  = len;
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.pattern = 8'($urandom);
    bus.length  = 4'($urandom);
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk);
      #1;
      obs_q.push_back(sample());
      bus.start = (c + 1 == restart_at) || (chain && (c + 1 >= ncyc));
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.pattern = '0; bus.length = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (all_outputs() !== 10'd0) begin
      failures++;
      $display("FAIL reset_values: got %b expected %b", all_outputs(), 10'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (all_outputs() !== 10'd0) begin
      failures++;
      $display("FAIL idle_after_reset: got %b expected %b", all_outputs(), 10'd0);
    end
  endtask

  task automatic test_basic();
    build_exp(8'b010, 3, done_cycle(3) + 1);
    run(8'b010, 4'd3, done_cycle(3) + 1, 0, 1'b0);
    for (int c = 0; c < exp_q.size(); c++) begin
      checks++;
      if (obs_q[c] !== exp_q[c]) begin
        failures++;
        $display("FAIL basic_010 cycle %0d: got %b expected %b", c + 1, obs_q[c], exp_q[c]);
      end
    end
    build_exp(8'b1111, 4, done_cycle(4) + 1);
    run(8'b1111, 4'd4, done_cycle(4) + 1, 0, 1'b0);
    for (int c = 0; c < exp_q.size(); c++) begin
      checks++;
      if (obs_q[c] !== exp_q[c]) begin
        failures++;
        $display("FAIL basic_1111 cycle %0d: got %b expected %b", c + 1, obs_q[c], exp_q[c]);
      end
    end
  endtask

  task automatic test_length_zero();
    build_exp(8'hA5, 0, done_cycle(0) + 2);
    run(8'hA5, 4'd0, done_cycle(0) + 2, 0, 1'b0);
    for (int c = 0; c < exp_q.size(); c++) begin
      checks++;
      if (obs_q[c] !== exp_q[c]) begin
        failures++;
        $display("FAIL length_zero cycle %0d: got %b expected %b", c + 1, obs_q[c], exp_q[c]);
      end
    end
  endtask

  task automatic test_clamp();
    logic [7:0] pat;
    pat = 8'($urandom);
    build_exp(pat, 12, done_cycle(12) + 1);
    run(pat, 4'd12, done_cycle(12) + 1, 0, 1'b0);
    for (int c = 0; c < exp_q.size(); c++) begin
      checks++;
      if (obs_q[c] !== exp_q[c]) begin
        failures++;
        $display("FAIL clamp_len12 cycle %0d: got %b expected %b", c + 1, obs_q[c], exp_q[c]);
      end
    end
  endtask

  task automatic test_restart_ignored();
    logic [7:0] pat;
    pat = 8'($urandom);
    build_exp(pat, 3, done_cycle(3) + 2);
    run(pat, 4'd3, done_cycle(3) + 2, 3, 1'b0);
    for (int c = 0; c < exp_q.size(); c++) begin
      checks++;
      if (obs_q[c] !== exp_q[c]) begin
        failures++;
        $display("FAIL restart_ignored cycle %0d: got %b expected %b", c + 1, obs_q[c], exp_q[c]);
      end
    end
  endtask

  // start held across the FIN->IDLE edge must only take effect on the following edge
  task automatic test_back_to_back();
    logic [7:0] pa, pb;
    logic [3:0] la, lb;
    pa = 8'($urandom); la = 4'($urandom_range(1, 5));
    pb = 8'($urandom); lb = 4'($urandom_range(0, 5));
    build_exp(pa, int'(la), done_cycle(int'(la)));
    run(pa, la, done_cycle(int'(la)), 0, 1'b1);
    for (int c = 0; c < exp_q.size(); c++) begin
      checks++;
      if (obs_q[c] !== exp_q[c]) begin
        failures++;
        $display("FAIL b2b_first cycle %0d: got %b expected %b", c + 1, obs_q[c], exp_q[c]);
      end
    end
    build_exp(pb, int'(lb), done_cycle(int'(lb)) + 1);
    run(pb, lb, done_cycle(int'(lb)) + 1, 0, 1'b0);
    for (int c = 0; c < exp_q.size(); c++) begin
      checks++;
      if (obs_q[c] !== exp_q[c]) begin
        failures++;
        $display("FAIL b2b_second cycle %0d: got %b expected %b", c + 1, obs_q[c], exp_q[c]);
      end
    end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    bus.start = 1'b1; bus.pattern = 8'b010; bus.length = 4'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (all_outputs() !== 10'd0) begin
      failures++;
      $display("FAIL reset_midflight_immediate: got %b expected %b", all_outputs(), 10'd0);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < done_cycle(3) + 2; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (sample() !== '0) begin
        failures++;
        $display("FAIL reset_midflight_quiet cycle %0d: got %b expected %b", c, sample(), 9'd0);
      end
    end
    build_exp(8'b110, 3, done_cycle(3) + 1);
    run(8'b110, 4'd3, done_cycle(3) + 1, 0, 1'b0);
    for (int c = 0; c < exp_q.size(); c++) begin
      checks++;
      if (obs_q[c] !== exp_q[c]) begin
        failures++;
        $display("FAIL after_reset_run cycle %0d: got %b expected %b", c + 1, obs_q[c], exp_q[c]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] pat;
    logic [3:0] len;
    for (int t = 0; t < 20; t++) begin
      pat = 8'($urandom);
      len = 4'($urandom_range(0, 15));
      build_exp(pat, int'(len), done_cycle(int'(len)) + 1);
      run(pat, len, done_cycle(int'(len)) + 1, 0, 1'b0);
      for (int c = 0; c < exp_q.size(); c++) begin
        checks++;
        if (obs_q[c] !== exp_q[c]) begin
          failures++;
          $display("FAIL random_%0d len=%0d cycle %0d: got %b expected %b",
                   t, len, c + 1, obs_q[c], exp_q[c]);
        end
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_length_zero();
    test_clamp();
    test_restart_ignored();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_stim_gen.md
Name: seq_stim_gen

Overview:
- Transmit-side companion to the team's serial sequence detector (seq_top).
- Takes a parallel bit pattern and a length, then serialises it MSB-first onto a `ser_in`/`ser_next` pair. Each bit is presented with a one-cycle `ser_next` strobe, exactly as the detector consumes it.
- Replaces hand-written `in`/`next` stimulus in benches; usable on-board to replay test patterns.

Parameters:
- MAX_LEN, 8: maximum pattern length in bits; width of `pattern`.
- LEN_W, 4: width of `length`; must satisfy 2^LEN_W > MAX_LEN.
- GAP, 1: idle cycles with `ser_next`=0 after each strobe; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request to send; sampled only in IDLE.
- pattern  input  MAX_LEN  bits to send; bit [length-1] goes first.
- length  input  LEN_W  number of bits to send; 0 is legal.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a transfer completes.
- ser_in  output  1  serial data bit to the detector's `in`.
- ser_next  output  1  one-cycle strobe to the detector's `next`.
- bit_idx  output  LEN_W  bits still to send, including the current one; for display.
- det_reset  output  1  detector reset pulse (see Optional Feature).

Behaviour:
- All outputs are registered.
- On reset, whether or not a transfer is in flight, every output goes to 0 and the state to IDLE. The shift register and counters clear; a partial transfer is abandoned with no done pulse.
- States: IDLE, RSTP (present only with the macro), DRIVE, GAP, FIN.
- IDLE, start=1 at a clock edge:
  - Capture `pattern`, and `length` clamped to MAX_LEN.
  - Load `bit_idx` with the clamped length.
  - Go to RSTP if the macro is enabled; otherwise DRIVE if length>0, else FIN.
  - start=0 in IDLE: hold.
- DRIVE (exactly 1 cycle):
  - `ser_next`=1; `ser_in` = pattern[bit_idx-1].
  - Next state GAP; gap counter loaded with GAP.
- GAP (GAP cycles):
  - `ser_next`=0; `ser_in` holds its last value.
  - On the last gap cycle, decrement `bit_idx`. Go to DRIVE if `bit_idx` was >1, else FIN.
- FIN (exactly 1 cycle): `done`=1, `busy`=1; then IDLE, where `done`=0 and `busy`=0.
- Timing, with the start edge at cycle 0:
  - `busy` rises at cycle 1.
  - The first strobe is at cycle 1 (without the macro).
  - Strobe k (k=0..len-1) is at cycle 1+k*(1+GAP).
  - `done` is at cycle 1+len*(1+GAP).
- length=0: no strobes; `done` at cycle 1.
- length>MAX_LEN: clamped to MAX_LEN; no error flag.
- `start` is ignored while busy, including during FIN.
- start asserted on the same edge as the return to IDLE is ignored. A new start is accepted no earlier than the first edge with state IDLE.
- `pattern` and `length` may change freely after capture without affecting the transfer.
- `ser_in` keeps its value after the transfer until the next DRIVE or reset. Its value outside DRIVE has no meaning to the detector.

Optional Feature:
- Macro: SEQ_STIM_GEN_DET_RESET_EN.
- Enabled:
  - After start is accepted, the FSM enters RSTP for 2 cycles with `det_reset`=1, `ser_next`=0 and `ser_in`=0, then proceeds to DRIVE, or to FIN if length=0.
  - All strobe and done timings shift later by 2 cycles.
  - `busy`=1 during RSTP.
- Disabled: RSTP does not exist and `det_reset` is constant 0.

Test Plan:
- Reset, then pattern=8'b010, length=3, start pulse, GAP=1:
  - Strobes at cycles 1, 3, 5 with `ser_in`=0, 1, 0.
  - `done` at cycle 7; `busy` high for cycles 1–7.
  - Loopback into seq_top: detector `out`=1 after the third strobe.
- pattern=8'b1111, length=4:
  - Strobes carry 1, 1, 1, 1 and `done` is at cycle 9.
  - Loopback: detector enters and holds its 111 lock state; `out` stays 0.
- length=0: no `ser_next` activity; `done`=1 at cycle 1; `busy`=1 only in cycle 1.
- length=12 with MAX_LEN=8: exactly 8 strobes; `bit_idx` loads 8; `done` at cycle 17.
- start re-pulsed at cycle 3 of a 3-bit transfer: ignored, with no change to strobe count or timing.
- Reset asserted at cycle 4 of a 3-bit transfer: all outputs 0 immediately and no `done` pulse. A fresh start afterwards completes normally.
- Same as the first test but with SEQ_STIM_GEN_DET_RESET_EN defined: `det_reset` high for cycles 1–2, strobes at 3/5/7, `done` at 9.
